// File: rtl/cpu_memory_pkg.sv
// Shared types for the memory stage: execute/memory records, bus state enum, width codes.
package CPU_Defines;

   localparam int TAG_W = 4;
   localparam int REG_W = 5;

   localparam logic [2:0] MEM_WIDTH_BYTE = 3'd1;
   localparam logic [2:0] MEM_WIDTH_HALF = 3'd2;
   localparam logic [2:0] MEM_WIDTH_WORD = 3'd4;

   typedef enum logic [1:0] {
      MEM_IDLE  = 2'd0,
      MEM_READ  = 2'd1,
      MEM_WRITE = 2'd2,
      MEM_FLUSH = 2'd3
   } mem_state_t;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [REG_W-1:0] inst_rd;
      logic [31:0]      rd;
      logic             mem_read;
      logic             mem_write;
      logic             mem_flush;
      logic [2:0]       mem_width;
      logic             mem_signed;
      logic [31:0]      mem_address;
      logic [REG_W-1:0] mem_inst_rd;
   } execute_data_t;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [REG_W-1:0] inst_rd;
      logic [31:0]      rd;
   } memory_data_t;

   function automatic logic width_ok(input logic [2:0] w);
      return (w == MEM_WIDTH_BYTE) || (w == MEM_WIDTH_HALF) || (w == MEM_WIDTH_WORD);
   endfunction

endpackage

// File: rtl/cpu_memory_lanes.sv
// Byte-lane steering: load extract with sign/zero extension, store mask and data replication.
module cpu_memory_lanes
   import CPU_Defines::*;
(
   input  logic [1:0]  i_addr,
   input  logic [2:0]  i_width,
   input  logic        i_signed,
   input  logic [31:0] i_sdata,
   input  logic [31:0] i_rdata,
   output logic [31:0] o_load,
   output logic [3:0]  o_wmask,
   output logic [31:0] o_wdata
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = i_rdata[7:0];
      case (i_addr)
         2'd1:    byte_sel = i_rdata[15:8];
         2'd2:    byte_sel = i_rdata[23:16];
         2'd3:    byte_sel = i_rdata[31:24];
         default: byte_sel = i_rdata[7:0];
      endcase
      half_sel = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];

      o_load  = '0;
      o_wmask = '0;
      o_wdata = i_sdata;
      case (i_width)
         MEM_WIDTH_BYTE: begin
            o_load  = {{24{i_signed & byte_sel[7]}}, byte_sel};
            o_wmask = 4'b0001 << i_addr;
            o_wdata = {4{i_sdata[7:0]}};
         end
         MEM_WIDTH_HALF: begin
            // addr[0] is dropped: a misaligned half lands on its aligned lane
            o_load  = {{16{i_signed & half_sel[15]}}, half_sel};
            o_wmask = 4'b0011 << {i_addr[1], 1'b0};
            o_wdata = {2{i_sdata[15:0]}};
         end
         MEM_WIDTH_WORD: begin
            o_load  = i_rdata;
            o_wmask = 4'hF;
            o_wdata = i_sdata;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/cpu_memory.sv
// Memory pipeline stage: loads/stores/flushes over a request/ready bus, stalls execute meanwhile.
// Optional CPU_MEMORY_ALIGN_FAULT_EN: misaligned half/word accesses fault instead of truncating.
module cpu_memory
   import CPU_Defines::*;
(
   input  logic          i_clock,
   input  logic          i_reset_n,
   output logic          o_fault,
   output logic          o_busy,
   input  execute_data_t i_data,
   output logic          o_bus_request,
   output logic          o_bus_rw,
   output logic          o_bus_flush,
   output logic [31:0]   o_bus_address,
   output logic [3:0]    o_bus_wmask,
   output logic [31:0]   o_bus_wdata,
   input  logic          i_bus_ready,
   input  logic [31:0]   i_bus_rdata,
   output memory_data_t  o_data
);

   mem_state_t       state_q, state_d;
   memory_data_t     out_q, out_d;
   logic             fault_q, fault_d;
   logic [31:0]      addr_q, addr_d;
   logic [2:0]       width_q, width_d;
   logic             signed_q, signed_d;
   logic [REG_W-1:0] inst_rd_q, inst_rd_d;
   logic [31:0]      sdata_q, sdata_d;

   logic        new_inst, mem_op, bad_access;
   logic [31:0] load_val, lane_wdata;
   logic [3:0]  lane_wmask;

   assign new_inst = (i_data.tag != out_q.tag);
   assign mem_op   = i_data.mem_read | i_data.mem_write | i_data.mem_flush;

`ifdef CPU_MEMORY_ALIGN_FAULT_EN
   assign bad_access = !width_ok(i_data.mem_width) ||
                       ((i_data.mem_width == MEM_WIDTH_HALF) && i_data.mem_address[0]) ||
                       ((i_data.mem_width == MEM_WIDTH_WORD) && (i_data.mem_address[1:0] != 2'd0));
`else
   assign bad_access = !width_ok(i_data.mem_width);
`endif

   cpu_memory_lanes u_lanes (
      .i_addr   (addr_q[1:0]),
      .i_width  (width_q),
      .i_signed (signed_q),
      .i_sdata  (sdata_q),
      .i_rdata  (i_bus_rdata),
      .o_load   (load_val),
      .o_wmask  (lane_wmask),
      .o_wdata  (lane_wdata)
   );

   always_comb begin
      state_d   = state_q;
      out_d     = out_q;
      fault_d   = fault_q;
      addr_d    = addr_q;
      width_d   = width_q;
      signed_d  = signed_q;
      inst_rd_d = inst_rd_q;
      sdata_d   = sdata_q;
      case (state_q)
         MEM_IDLE: begin
            if (new_inst && !mem_op) begin
               out_d.tag     = i_data.tag;
               out_d.inst_rd = i_data.inst_rd;
               out_d.rd      = i_data.rd;
            end else if (new_inst && bad_access) begin
               fault_d       = 1'b1;
               out_d.tag     = i_data.tag;
               out_d.inst_rd = '0;
               out_d.rd      = '0;
            end else if (new_inst) begin
               addr_d    = i_data.mem_address;
               width_d   = i_data.mem_width;
               signed_d  = i_data.mem_signed;
               inst_rd_d = i_data.mem_inst_rd;
               sdata_d   = i_data.rd;
               if (i_data.mem_flush)      state_d = MEM_FLUSH;
               else if (i_data.mem_write) state_d = MEM_WRITE;
               else                       state_d = MEM_READ;
            end
         end
         MEM_READ: begin
            if (i_bus_ready) begin
               state_d       = MEM_IDLE;
               out_d.tag     = i_data.tag;
               out_d.inst_rd = inst_rd_q;
               out_d.rd      = load_val;
            end
         end
         default: begin
            if (i_bus_ready) begin
               state_d       = MEM_IDLE;
               out_d.tag     = i_data.tag;
               out_d.inst_rd = '0;
               out_d.rd      = '0;
            end
         end
      endcase
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q   <= MEM_IDLE;
         out_q     <= '0;
         fault_q   <= 1'b0;
         addr_q    <= '0;
         width_q   <= '0;
         signed_q  <= 1'b0;
         inst_rd_q <= '0;
         sdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         out_q     <= out_d;
         fault_q   <= fault_d;
         addr_q    <= addr_d;
         width_q   <= width_d;
         signed_q  <= signed_d;
         inst_rd_q <= inst_rd_d;
         sdata_q   <= sdata_d;
      end
   end

   // Bus outputs come straight from flops latched at acceptance, so they cannot move mid-request
   assign o_bus_request = (state_q != MEM_IDLE);
   assign o_bus_rw      = (state_q == MEM_WRITE);
   assign o_bus_flush   = (state_q == MEM_FLUSH);
   assign o_bus_address = {addr_q[31:2], 2'b00};
   assign o_bus_wmask   = o_bus_rw ? lane_wmask : 4'h0;
   assign o_bus_wdata   = lane_wdata;

   assign o_busy  = (state_q != MEM_IDLE) || (new_inst && mem_op);
   assign o_fault = fault_q;
   assign o_data  = out_q;

endmodule

// File: tb/tb_cpu_memory.sv
// Directed bench for cpu_memory: pass-through, loads, stores, flush, faults, reset abort.
module tb_cpu_memory;
   import CPU_Defines::*;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          fault, busy, req, rw, flush, ready;
   logic [31:0]   addr, wdata, rdata;
   logic [3:0]    wmask;
   execute_data_t din;
   memory_data_t  dout;

   int n_tot = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   cpu_memory dut (
      .i_clock       (clk),
      .i_reset_n     (rst_n),
      .o_fault       (fault),
      .o_busy        (busy),
      .i_data        (din),
      .o_bus_request (req),
      .o_bus_rw      (rw),
      .o_bus_flush   (flush),
      .o_bus_address (addr),
      .o_bus_wmask   (wmask),
      .o_bus_wdata   (wdata),
      .i_bus_ready   (ready),
      .i_bus_rdata   (rdata),
      .o_data        (dout)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask

   task automatic drive(input logic [3:0] tag, input logic rd_f, input logic wr_f, input logic fl_f,
                        input logic [2:0] w, input logic sg, input logic [31:0] a,
                        input logic [31:0] d, input logic [4:0] ird, input logic [4:0] mird);
      din             = '0;
      din.tag         = tag;
      din.mem_read    = rd_f;
      din.mem_write   = wr_f;
      din.mem_flush   = fl_f;
      din.mem_width   = w;
      din.mem_signed  = sg;
      din.mem_address = a;
      din.rd          = d;
      din.inst_rd     = ird;
      din.mem_inst_rd = mird;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   // Called right after drive(); accepts, holds the request lat cycles, pulses ready on the last one.
   task automatic run_mem(input string nm, input int lat, input logic [31:0] rdat,
                          input logic [31:0] e_addr, input logic e_rw, input logic e_fl,
                          input logic [3:0] e_mask, input logic [31:0] e_wdata,
                          output int busy_cyc);
      busy_cyc = 0;
      #1;
      if (busy) busy_cyc++;
      @(posedge clk);
      for (int c = 1; c <= lat; c++) begin
         @(negedge clk);
         if (c == lat) begin
            ready = 1'b1;
            rdata = rdat;
         end
         #1;
         if (busy) busy_cyc++;
         if (c == 1) begin
            chk({nm, " req"}, {31'd0, req}, 32'd1);
            chk({nm, " rw"}, {31'd0, rw}, {31'd0, e_rw});
            chk({nm, " flush"}, {31'd0, flush}, {31'd0, e_fl});
            chk({nm, " addr"}, addr, e_addr);
            chk({nm, " wmask"}, {28'd0, wmask}, {28'd0, e_mask});
            if (e_rw) chk({nm, " wdata"}, wdata, e_wdata);
         end
         if (c == lat && lat > 1) begin
            chk({nm, " hold addr"}, addr, e_addr);
            chk({nm, " hold mask"}, {28'd0, wmask}, {28'd0, e_mask});
            chk({nm, " hold req"}, {31'd0, req}, 32'd1);
         end
         @(posedge clk);
      end
      @(negedge clk);
      ready = 1'b0;
      rdata = 32'h0;
      #1;
      chk({nm, " req drop"}, {31'd0, req}, 32'd0);
      chk({nm, " busy drop"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int bc;
      ready = 1'b0;
      rdata = '0;
      din   = '0;
      #12;
      chk("rst data", dout[31:0], 32'd0);
      chk("rst tag", {28'd0, dout.tag}, 32'd0);
      chk("rst fault", {31'd0, fault}, 32'd0);
      chk("rst req", {31'd0, req}, 32'd0);
      chk("rst addr", addr, 32'd0);
      chk("rst wmask/wdata", {28'd0, wmask} | wdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // ALU pass-through
      drive(4'd1, 0, 0, 0, 3'd0, 0, 32'd0, 32'h0000_0011, 5'd3, 5'd0);
      #1 chk("alu1 busy", {31'd0, busy}, 32'd0);
      step();
      chk("alu1 tag", {28'd0, dout.tag}, 32'd1);
      drive(4'd2, 0, 0, 0, 3'd0, 0, 32'd0, 32'h0000_1234, 5'd5, 5'd0);
      #1 chk("alu2 busy", {31'd0, busy}, 32'd0);
      step();
      chk("alu2 tag", {28'd0, dout.tag}, 32'd2);
      chk("alu2 inst_rd", {27'd0, dout.inst_rd}, 32'd5);
      chk("alu2 rd", dout.rd, 32'h0000_1234);

      // signed byte load, ready in the third request cycle
      drive(4'd3, 1, 0, 0, MEM_WIDTH_BYTE, 1, 32'h103, 32'd0, 5'd0, 5'd7);
      run_mem("lb", 3, 32'h80FF_FF7F, 32'h100, 0, 0, 4'h0, 32'h0, bc);
      chk("lb busy cycles", bc, 32'd4);
      chk("lb rd", dout.rd, 32'hFFFF_FF80);
      chk("lb inst_rd", {27'd0, dout.inst_rd}, 32'd7);
      chk("lb tag", {28'd0, dout.tag}, 32'd3);

      // half store
      drive(4'd4, 0, 1, 0, MEM_WIDTH_HALF, 0, 32'h202, 32'h0000_BEEF, 5'd0, 5'd6);
      run_mem("sh", 2, 32'h0, 32'h200, 1, 0, 4'b1100, 32'hBEEF_BEEF, bc);
      chk("sh inst_rd", {27'd0, dout.inst_rd}, 32'd0);
      chk("sh tag", {28'd0, dout.tag}, 32'd4);

      // unsigned half load, minimum latency
      drive(4'd5, 1, 0, 0, MEM_WIDTH_HALF, 0, 32'h6, 32'd0, 5'd0, 5'd9);
      run_mem("lhu", 1, 32'h9ABC_0000, 32'h4, 0, 0, 4'h0, 32'h0, bc);
      chk("lhu busy cycles", bc, 32'd2);
      chk("lhu rd", dout.rd, 32'h0000_9ABC);
      chk("lhu inst_rd", {27'd0, dout.inst_rd}, 32'd9);

      // misaligned word load
      drive(4'd6, 1, 0, 0, MEM_WIDTH_WORD, 0, 32'h101, 32'd0, 5'd0, 5'd10);
`ifdef CPU_MEMORY_ALIGN_FAULT_EN
      step();
      chk("lw mis fault", {31'd0, fault}, 32'd1);
      chk("lw mis req", {31'd0, req}, 32'd0);
      chk("lw mis inst_rd", {27'd0, dout.inst_rd}, 32'd0);
      chk("lw mis tag", {28'd0, dout.tag}, 32'd6);
`else
      run_mem("lw mis", 1, 32'h1122_3344, 32'h100, 0, 0, 4'h0, 32'h0, bc);
      chk("lw mis rd", dout.rd, 32'h1122_3344);
      chk("lw mis fault", {31'd0, fault}, 32'd0);
`endif

      // illegal width
      drive(4'd7, 1, 0, 0, 3'd3, 0, 32'h10, 32'd0, 5'd0, 5'd11);
      #1 chk("bad w busy", {31'd0, busy}, 32'd1);
      step();
      chk("bad w fault", {31'd0, fault}, 32'd1);
      chk("bad w req", {31'd0, req}, 32'd0);
      chk("bad w inst_rd", {27'd0, dout.inst_rd}, 32'd0);
      chk("bad w tag", {28'd0, dout.tag}, 32'd7);

      // flush beats write
      drive(4'd8, 0, 1, 1, MEM_WIDTH_WORD, 0, 32'h40, 32'h5555_AAAA, 5'd0, 5'd0);
      run_mem("fl", 2, 32'h0, 32'h40, 0, 1, 4'h0, 32'h0, bc);
      chk("fl tag", {28'd0, dout.tag}, 32'd8);
      chk("fault sticky", {31'd0, fault}, 32'd1);

      // byte store
      drive(4'd9, 0, 1, 0, MEM_WIDTH_BYTE, 0, 32'h301, 32'h1234_56A5, 5'd0, 5'd0);
      run_mem("sb", 1, 32'h0, 32'h300, 1, 0, 4'b0010, 32'hA5A5_A5A5, bc);

      // stray ready while idle
      ready = 1'b1;
      rdata = 32'hDEAD_BEEF;
      step();
      ready = 1'b0;
      chk("stray ready req", {31'd0, req}, 32'd0);
      chk("stray ready tag", {28'd0, dout.tag}, 32'd9);

      // reset while requesting
      drive(4'd10, 1, 0, 0, MEM_WIDTH_WORD, 0, 32'h80, 32'd0, 5'd0, 5'd12);
      step();
      chk("abort req before", {31'd0, req}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort req", {31'd0, req}, 32'd0);
      chk("abort data", dout[31:0], 32'd0);
      chk("abort fault", {31'd0, fault}, 32'd0);
      drive(4'd0, 0, 0, 0, 3'd0, 0, 32'd0, 32'd0, 5'd0, 5'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("post rst req", {31'd0, req}, 32'd0);
      chk("post rst busy", {31'd0, busy}, 32'd0);
      chk("post rst tag", {28'd0, dout.tag}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running want finished");
      $fatal(1);
   end

endmodule
